// File: rtl/image_rx_protocol.sv
// image_rx_protocol: UART image receive engine with ASCII header, chunk ACKs, checksum check and idle timeout
module image_rx_protocol #(
  parameter int CHUNK_SIZE     = 256,
  parameter int SIZE_W         = 24,
  parameter int MAX_HDR_LEN    = 32,
  parameter int TIMEOUT_CYCLES = 27_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        data_out,
  output logic              data_valid,
  output logic              image_start,
  output logic              chunk_complete,
  output logic              image_end,
  output logic              image_ok,
  output logic              image_err,
  output logic [SIZE_W-1:0] byte_count
);
  localparam logic [7:0] SOH = 8'h01, ETX = 8'h03, ACK = 8'h06, LF = 8'h0A;
  localparam logic [7:0] COMMA = 8'h2C, DONE = 8'h16, NAK = 8'h15, CAN = 8'h18;
  localparam int CW = $clog2(CHUNK_SIZE + 1);
  localparam int HW = $clog2(MAX_HDR_LEN + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Aborts go straight to TX with CAN queued, so the reply and image_err land one cycle after the cause.
  typedef enum logic [2:0] {IDLE, HDR_SIZE, HDR_CKSUM, TX, DATA, WAIT_END} state_t;

  state_t state_q, state_d, ret_q, ret_d;
  logic [7:0] tx_data_q, tx_data_d, dout_q, dout_d;
  logic [SIZE_W-1:0] size_q, size_d, cnt_q, cnt_d;
  logic [15:0] ck_q, ck_d, sum_q, sum_d;
  logic [CW-1:0] chunk_q, chunk_d;
  logic [HW-1:0] hlen_q, hlen_d;
  logic [TW-1:0] idle_q, idle_d;
  logic dv_q, dv_d, start_q, start_d, cc_q, cc_d, end_q, end_d, ok_q, ok_d, err_q, err_d;
  logic is_dig, abort, timed;
  logic [3:0] dig;

  assign is_dig = rx_data >= 8'h30 && rx_data <= 8'h39;
  assign dig = rx_data[3:0];
  assign tx_valid = state_q == TX;
  assign tx_data = tx_data_q;
  assign data_out = dout_q;
  assign data_valid = dv_q;
  assign image_start = start_q;
  assign chunk_complete = cc_q;
  assign image_end = end_q;
  assign image_ok = ok_q;
  assign image_err = err_q;
  assign byte_count = cnt_q;

  // Next-state, header parsing, payload accounting and pulse generation
  always_comb begin
    state_d = state_q;
    ret_d = ret_q;
    tx_data_d = tx_data_q;
    size_d = size_q;
    ck_d = ck_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    chunk_d = chunk_q;
    hlen_d = hlen_q;
    dout_d = dout_q;
    idle_d = '0;
    dv_d = 1'b0;
    start_d = 1'b0;
    cc_d = 1'b0;
    end_d = 1'b0;
    ok_d = 1'b0;
    err_d = 1'b0;
    abort = 1'b0;
    timed = state_q inside {HDR_SIZE, HDR_CKSUM, DATA, WAIT_END};
    if (timed && !rx_valid) begin
      idle_d = idle_q + 1'b1;
      abort = idle_d == TW'(TIMEOUT_CYCLES);
    end
    case (state_q)
      IDLE: if (rx_valid && rx_data == SOH) begin
        state_d = HDR_SIZE;
        size_d = '0;
        ck_d = '0;
        hlen_d = '0;
      end
      HDR_SIZE, HDR_CKSUM: if (rx_valid) begin
        hlen_d = hlen_q + 1'b1;
        if (hlen_q == HW'(MAX_HDR_LEN)) abort = 1'b1;
        else if (is_dig && state_q == HDR_SIZE) size_d = size_q * SIZE_W'(10) + SIZE_W'(dig);
        else if (is_dig) ck_d = ck_q * 16'd10 + 16'(dig);
        else if (state_q == HDR_SIZE && rx_data == COMMA) state_d = HDR_CKSUM;
        else if (state_q == HDR_CKSUM && rx_data == LF) begin
          start_d = 1'b1;
          cnt_d = '0;
          sum_d = '0;
          chunk_d = '0;
          tx_data_d = ACK;
          state_d = TX;
          ret_d = size_q == '0 ? WAIT_END : DATA;
        end
        else abort = 1'b1;
      end
      TX: if (tx_ready) state_d = ret_q;
      DATA: if (rx_valid) begin
        dv_d = 1'b1;
        dout_d = rx_data;
        cnt_d = cnt_q + 1'b1;
        sum_d = sum_q + 16'(rx_data);
        chunk_d = chunk_q == CW'(CHUNK_SIZE - 1) ? '0 : chunk_q + 1'b1;
        if (cnt_d == size_q) begin
          cc_d = 1'b1;
          state_d = WAIT_END;
        end else if (chunk_q == CW'(CHUNK_SIZE - 1)) begin
          cc_d = 1'b1;
          tx_data_d = ACK;
          state_d = TX;
          ret_d = DATA;
        end
      end
      WAIT_END: if (rx_valid) begin
        if (rx_data == ETX) begin
          end_d = 1'b1;
          ok_d = sum_q == ck_q;
          err_d = sum_q != ck_q;
          tx_data_d = sum_q == ck_q ? DONE : NAK;
          state_d = TX;
          ret_d = IDLE;
        end else abort = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      err_d = 1'b1;
      tx_data_d = CAN;
      state_d = TX;
      ret_d = IDLE;
    end
  end

  // State and datapath registers; reset abandons any image in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ret_q <= IDLE;
      tx_data_q <= '0;
      dout_q <= '0;
      size_q <= '0;
      cnt_q <= '0;
      ck_q <= '0;
      sum_q <= '0;
      chunk_q <= '0;
      hlen_q <= '0;
      idle_q <= '0;
      dv_q <= 1'b0;
      start_q <= 1'b0;
      cc_q <= 1'b0;
      end_q <= 1'b0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      tx_data_q <= tx_data_d;
      dout_q <= dout_d;
      size_q <= size_d;
      cnt_q <= cnt_d;
      ck_q <= ck_d;
      sum_q <= sum_d;
      chunk_q <= chunk_d;
      hlen_q <= hlen_d;
      idle_q <= idle_d;
      dv_q <= dv_d;
      start_q <= start_d;
      cc_q <= cc_d;
      end_q <= end_d;
      ok_q <= ok_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_image_rx_protocol.sv
// tb_image_rx_protocol: randomized host-side stimulus checked against a queue-based model of the image link
module tb_image_rx_protocol;
  localparam int CHUNK = 256, SW = 24, MAXH = 32, TO = 100;
  typedef logic [7:0] bq_t[$];

  logic clk = 0, rst = 1, rx_valid = 0, tx_ready = 1;
  logic [7:0] rx_data = 0;
  logic [7:0] tx_data, data_out;
  logic tx_valid, data_valid, image_start, chunk_complete, image_end, image_ok, image_err;
  logic [SW-1:0] byte_count;
  int checks = 0, fails = 0;
  int n_start = 0, n_end = 0, n_ok = 0, n_err = 0, n_chunk = 0;
  int exp_size = 0, idx;
  bq_t exp_tx, exp_data, got_tx;
  logic prev_hold = 0;
  logic [7:0] prev_tx = 0;
  logic [3:0] p, prev_p = 0;

  always #5 clk = ~clk;

  image_rx_protocol #(.CHUNK_SIZE(CHUNK), .SIZE_W(SW), .MAX_HDR_LEN(MAXH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .data_out(data_out), .data_valid(data_valid), .image_start(image_start),
    .chunk_complete(chunk_complete), .image_end(image_end), .image_ok(image_ok),
    .image_err(image_err), .byte_count(byte_count));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic bq_t dec(input longint v, input int pad);
    bq_t q;
    longint x = v;
    do begin
      q.push_front(8'h30 + 8'(x % 10));
      x = x / 10;
    end while (x != 0);
    while (q.size() < pad) q.push_front(8'h30);
    return q;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic logic [15:0] sum16(input bq_t q);
    logic [15:0] s = 0;
    foreach (q[i]) s += 16'(q[i]);
    return s;
  endfunction

  // Every cycle: payload bytes, replies and pulses against the model's queues
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold) begin
        check("tx_hold_valid", tx_valid, 1);
        check("tx_hold_data", tx_data, prev_tx);
      end
      prev_hold = tx_valid && !tx_ready;
      prev_tx = tx_data;
      if (tx_valid && tx_ready) begin
        got_tx.push_back(tx_data);
        if (exp_tx.size() == 0) begin
          checks++; fails++;
          $display("FAIL tx_extra: got reply %02h, required none", tx_data);
        end else check("tx_byte", tx_data, exp_tx.pop_front());
      end
      if (data_valid) begin
        if (exp_data.size() == 0) begin
          checks++; fails++;
          $display("FAIL data_extra: got data_out %02h, required no payload byte", data_out);
        end else begin
          idx = exp_size - exp_data.size() + 1;
          check("data_out", data_out, exp_data.pop_front());
          check("byte_count", byte_count, idx);
          check("chunk_complete", chunk_complete, (idx % CHUNK == 0) || (idx == exp_size));
        end
      end else if (chunk_complete) check("chunk_without_data", chunk_complete, 0);
      p = {image_start, image_end, image_ok, image_err};
      if (|p) check("pulse_width", p & prev_p, 0);
      prev_p = p;
      n_start += int'(image_start);
      n_end += int'(image_end);
      n_ok += int'(image_ok);
      n_err += int'(image_err);
      n_chunk += int'(chunk_complete);
    end else begin
      prev_hold = 0;
      prev_p = 0;
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1;
    @(posedge clk); #1;
    rx_valid = 0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_hdr(input longint szf, input longint ckf, input int pad);
    bq_t h;
    send(8'h01);
    h = dec(szf, pad);
    foreach (h[i]) send(h[i]);
    send(8'h2C);
    h = dec(ckf, 0);
    foreach (h[i]) send(h[i]);
    send(8'h0A);
  endtask

  task automatic wait_tx(input bit rr);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (rr) tx_ready = ($urandom % 3) != 0;
      @(negedge clk);
      done = tx_valid && tx_ready;
      @(posedge clk); #1;
    end
    tx_ready = 1;
    if (!done) begin
      checks++; fails++;
      $display("FAIL tx_timeout: got no reply within 300 cycles, required one");
    end
  endtask

  task automatic image(input longint szf, input longint ckf, input int pad, input int gmax, input bit rr, input bq_t pay);
    int sz, s0, e0, o0, r0, c0;
    logic [15:0] s;
    bit good;
    sz = int'(szf % (64'd1 << SW));
    s = sum16(pay);
    good = s == 16'(ckf);
    s0 = n_start; e0 = n_end; o0 = n_ok; r0 = n_err; c0 = n_chunk;
    exp_size = sz;
    exp_data = pay;
    exp_tx.push_back(8'h06);
    for (int k = CHUNK; k < sz; k += CHUNK) exp_tx.push_back(8'h06);
    exp_tx.push_back(good ? 8'h16 : 8'h15);
    send_hdr(szf, ckf, pad);
    wait_tx(rr);
    for (int i = 0; i < sz; i++) begin
      send(pay[i]);
      if ((i + 1) % CHUNK == 0 && i + 1 < sz) wait_tx(rr);
      else gap($urandom_range(gmax));
    end
    send(8'h03);
    wait_tx(rr);
    check("img_start_cnt", n_start - s0, 1);
    check("img_end_cnt", n_end - e0, 1);
    check("img_ok_cnt", n_ok - o0, good ? 1 : 0);
    check("img_err_cnt", n_err - r0, good ? 0 : 1);
    check("img_chunk_cnt", n_chunk - c0, (sz + CHUNK - 1) / CHUNK);
    check("img_bytes_left", exp_data.size(), 0);
    check("img_replies_left", exp_tx.size(), 0);
    check("img_byte_count", byte_count, sz);
  endtask

  task automatic bad_hdr(input bq_t h, input string tag);
    int e0 = n_err;
    got_tx.delete();
    exp_tx.push_back(8'h18);
    send(8'h01);
    foreach (h[i]) send(h[i]);
    wait_tx(0);
    check({tag, "_reply"}, got_tx.size() > 0 ? got_tx[0] : 8'h00, 8'h18);
    check({tag, "_err"}, n_err - e0, 1);
  endtask

  task automatic zero_check(input string tag);
    check({tag, "_flags"}, {tx_valid, data_valid, image_start, chunk_complete, image_end, image_ok, image_err}, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_byte_count"}, byte_count, 0);
  endtask

  task automatic pulse_rst(input string tag);
    #1 rst = 1;
    #1 zero_check(tag);
    exp_tx.delete();
    exp_data.delete();
    @(posedge clk); #1 rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test by 1 ms, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t pay, h;
    int c0, e0, o0, lat;
    longint ck;
    repeat (3) @(posedge clk);
    #1 zero_check("reset");
    rst = 0;
    gap(2);

    pay = rand_bytes(600);
    got_tx.delete();
    c0 = n_chunk;
    image(600, sum16(pay), 0, 0, 0, pay);
    check("p600_reply_count", got_tx.size(), 4);
    check("p600_last_reply", got_tx.size() == 4 ? got_tx[3] : 8'h00, 8'h16);
    check("p600_chunks", n_chunk - c0, 3);
    check("p600_byte_count", byte_count, 600);

    pay = '{8'h01, 8'h03, 8'h03, 8'h00};
    got_tx.delete();
    image(4, 7, 0, 1, 0, pay);
    check("ctl_bytes_replies", got_tx.size(), 2);
    check("ctl_bytes_done", got_tx.size() == 2 ? got_tx[1] : 8'h00, 8'h16);

    pay = '{8'h05, 8'h05};
    got_tx.delete();
    e0 = n_err;
    image(2, 9, 0, 0, 0, pay);
    check("bad_ck_nak", got_tx.size() == 2 ? got_tx[1] : 8'h00, 8'h15);
    check("bad_ck_err", n_err - e0, 1);

    h = '{8'h31, 8'h32, 8'h78};
    bad_hdr(h, "bad_hdr");
    image(3, 0, 0, 1, 1, rand_bytes(3));

    pay = '{8'h01, 8'h03, 8'h03, 8'h00};
    image(4, 7, 29, 0, 0, pay);
    h = dec(4, 30);
    h.push_back(8'h2C); h.push_back(8'h37); h.push_back(8'h0A);
    bad_hdr(h, "hdr_too_long");

    pay = '{8'h05, 8'h05};
    got_tx.delete();
    image(16777218, 10 + 65536, 0, 0, 0, pay);
    check("trunc_done", got_tx.size() == 2 ? got_tx[1] : 8'h00, 8'h16);

    got_tx.delete();
    o0 = n_ok;
    exp_size = 0;
    exp_tx.push_back(8'h06);
    exp_tx.push_back(8'h16);
    send(8'h01); send(8'h2C); send(8'h0A);
    wait_tx(1);
    send(8'h03);
    wait_tx(1);
    check("empty_fields_done", got_tx.size() == 2 ? got_tx[1] : 8'h00, 8'h16);
    check("empty_fields_ok", n_ok - o0, 1);

    pay = rand_bytes(20);
    got_tx.delete();
    e0 = n_err;
    exp_size = 20;
    exp_data = pay;
    exp_tx.push_back(8'h06);
    exp_tx.push_back(8'h18);
    send_hdr(20, 0, 0);
    wait_tx(0);
    for (int i = 0; i < 10; i++) send(pay[i]);
    lat = 0;
    for (int i = 1; i <= 150 && lat == 0; i++) begin
      @(negedge clk);
      if (tx_valid) lat = i;
    end
    check("timeout_latency", lat, TO + 1);
    @(posedge clk); #1;
    exp_data.delete();
    check("timeout_can", got_tx.size() == 2 ? got_tx[1] : 8'h00, 8'h18);
    check("timeout_err", n_err - e0, 1);

    pay = rand_bytes(3);
    exp_size = 3;
    exp_data = pay;
    exp_tx.push_back(8'h06);
    tx_ready = 0;
    send_hdr(3, 0, 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("bp_tx_valid", tx_valid, 1);
      check("bp_tx_data", tx_data, 8'h06);
      rx_data = 8'($urandom);
      rx_valid = 1'($urandom);
    end
    @(posedge clk); #1;
    rx_valid = 0;
    tx_ready = 1;
    wait_tx(0);
    send(pay[0]);
    check("dv_before_rst", data_valid, 1);
    pulse_rst("rst_data");

    exp_tx.push_back(8'h06);
    tx_ready = 0;
    send_hdr(1, 0, 0);
    @(negedge clk);
    check("tx_before_rst", tx_valid, 1);
    @(posedge clk); #1;
    pulse_rst("rst_tx");
    tx_ready = 1;

    for (int r = 0; r < 10; r++) begin
      int sel, sz;
      sel = $urandom_range(5);
      sz = sel == 0 ? 0 : sel == 1 ? 1 : sel == 2 ? 256 : sel == 3 ? 257 : $urandom_range(700, 2);
      pay = rand_bytes(sz);
      ck = ($urandom % 4 != 0) ? longint'(sum16(pay)) + 65536 * longint'($urandom_range(2))
                               : longint'(sum16(pay)) + 1 + longint'($urandom_range(60000));
      image(sz, ck, $urandom_range(3), $urandom_range(3), 1'($urandom), pay);
    end

    gap(3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/image_rx_protocol.md
# image_rx_protocol

Parametrised receive-side protocol engine for the UART image link, sitting between a byte-level UART core and the image store. It parses an ASCII header carrying the image size and checksum, streams exactly that many payload bytes to the store, and handshakes READY/ACK per chunk. It then verifies a 16-bit additive checksum and reports success or failure to the host. Unlike the previous generation it is length-delimited, so payload bytes equal to control codes are legal. It also adds checksum verification, an inactivity timeout and explicit error replies.

## Interface
- CHUNK_SIZE, 256: payload bytes between ACKs; ≥1.
- SIZE_W, 24: width of the image size field and byte counter.
- MAX_HDR_LEN, 32: maximum header characters after SOH, terminator included.
- TIMEOUT_CYCLES, 27_000_000: idle-cycle limit while an image is in progress (1 s at 27 MHz).

- clk  in  1  system clock, 27 MHz.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  byte from the UART core.
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure.
- tx_data  out  8  reply byte to the UART core.
- tx_valid  out  1  reply pending; held with tx_data until accepted.
- tx_ready  in  1  UART core can accept; transfer when tx_valid & tx_ready at the clock edge.
- data_out  out  8  payload byte to the store.
- data_valid  out  1  one-cycle strobe for data_out.
- image_start  out  1  pulse: header accepted.
- chunk_complete  out  1  pulse with the data_valid of each CHUNK_SIZE-th byte.
- image_end  out  1  pulse: ETX received after the full payload.
- image_ok  out  1  pulse: checksum matched.
- image_err  out  1  pulse: checksum mismatch, header error or timeout.
- byte_count  out  SIZE_W  payload bytes delivered in the current image.

## Operation
- Codes: SOH 0x01, ETX 0x03, READY/ACK 0x06, LF 0x0A, ',' 0x2C, DONE 0x16, NAK 0x15, CAN 0x18.
- Header after SOH: decimal size digits, ',', decimal checksum digits, LF. Digits accumulate as acc*10 + (c - 0x30). Size is truncated to SIZE_W bits; checksum is taken mod 2^16. An empty digit field reads as 0.
- States: IDLE, HDR_SIZE, HDR_CKSUM, TX, DATA, WAIT_END, ABORT.
- IDLE: SOH → HDR_SIZE; clear accumulators and header length. All other bytes are ignored.
- HDR_SIZE: digit → accumulate; ',' → HDR_CKSUM; any other byte → ABORT.
- HDR_CKSUM: digit → accumulate; LF → pulse image_start, clear byte_count and the running sum, queue READY; any other byte → ABORT.
- Header length above MAX_HDR_LEN → ABORT.
- TX: drive tx_valid/tx_data until the transfer completes, then go to the queued return state.
  - After READY: DATA, or WAIT_END if size = 0.
  - After ACK: DATA.
  - After DONE, NAK or CAN: IDLE.
- rx_valid is ignored while in TX.
- DATA: each byte drives data_out and data_valid, increments byte_count, and adds to sum[15:0] mod 2^16. No byte value is special.
  - byte_count reaches size → pulse chunk_complete if byte_count mod CHUNK_SIZE = 0 (or byte_count = size), then go to WAIT_END without sending ACK.
  - Else byte_count mod CHUNK_SIZE = 0 → pulse chunk_complete and queue ACK.
- WAIT_END: ETX → pulse image_end. Then:
  - sum = checksum → queue DONE and pulse image_ok.
  - Otherwise → queue NAK and pulse image_err.
  - Any other byte → ABORT.
- ABORT: pulse image_err, queue CAN.
- Timeout: in HDR_*, DATA or WAIT_END, an idle counter clears on every rx_valid. When it reaches TIMEOUT_CYCLES → ABORT. The counter does not run in IDLE or TX.

## Timing
- Reset values: tx_valid, data_valid, and every pulse output are 0. tx_data, data_out and byte_count are 0. State is IDLE.
- Asserting rst drops tx_valid immediately and abandons any image in progress.
- data_out and data_valid are registered: they assert on the cycle after the rx_valid cycle.
- image_start, image_end, image_ok and image_err assert on the cycle after the triggering byte or event.
- chunk_complete coincides with the last byte's data_valid.
- tx_valid rises on the cycle after the triggering byte or event. tx_data stays stable while tx_valid = 1 and tx_ready = 0.
- tx_valid deasserts on the cycle after the accepting edge.
- All pulse outputs are exactly 1 cycle wide.
- rx_valid may arrive on back-to-back cycles in DATA; every strobe must be processed with no loss.

## Test plan
- Payload case: SOH "600,<sum>" LF, 600 bytes, ETX.
  - → READY, then ACK after bytes 256 and 512 only.
  - → three chunk_complete pulses; byte_count = 600.
  - → DONE and image_ok.
- Payload containing 0x03 and 0x01: SOH "4,7" LF, bytes 01 03 03 00, ETX → all 4 bytes delivered; DONE.
- Wrong checksum: SOH "2,9" LF, 05 05, ETX → NAK 0x15 and an image_err pulse.
- Bad header: SOH "12x" → CAN 0x18 and image_err; the next SOH header is accepted normally.
- Timeout: TIMEOUT_CYCLES = 100; stop after 10 of 20 payload bytes → CAN at cycle 100 of silence, then IDLE.
- Backpressure and reset:
  - Hold tx_ready = 0 for 50 cycles during READY → tx_valid and tx_data = 0x06 stay stable.
  - Assert rst mid-DATA → all outputs return to 0 immediately.
